// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder shared by two requesters: round-robin capture, LSB-first add over WIDTH
// cycles with a registered carry, then a one-cycle done pulse tagged with the owner.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             cin0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             cin1,
   output logic             ack0,
   output logic             ack1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;
   logic [CntW-1:0]  count_q;
   logic             carry_q, owner_q, last_q;

   logic             s_bit, co_bit, grant1;
   logic [WIDTH-1:0] sum_sh_d;

   always_comb begin
      s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      co_bit   = (a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & carry_q) | (a_sh_q[0] & carry_q);
      // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
      sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
      // On a tie the requester that was not served last wins.
      grant1   = req1 & (~req0 | ~last_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         count_q  <= '0;
         carry_q  <= 1'b0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         done_id  <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (req0 | req1) begin
                  if (grant1) begin
                     a_sh_q  <= a1;
                     b_sh_q  <= b1;
                     carry_q <= cin1;
                     ack1    <= 1'b1;
                  end else begin
                     a_sh_q  <= a0;
                     b_sh_q  <= b0;
                     carry_q <= cin0;
                     ack0    <= 1'b1;
                  end
                  owner_q <= grant1;
                  last_q  <= grant1;
                  count_q <= '0;
                  busy    <= 1'b1;
                  state_q <= StShift;
               end
            end
            StShift: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               carry_q  <= co_bit;
               sum_sh_q <= sum_sh_d;
               count_q  <= count_q + CntW'(1);
               if (count_q == CntW'(WIDTH - 1)) begin
                  sum     <= sum_sh_d;
                  cout    <= co_bit;
                  done_id <= owner_q;
                  done    <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, multi-cycle corner
// sequences and random operations against an arithmetic reference.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic         cin0 = 1'b0, cin1 = 1'b0;
   logic         ack0, ack1, busy, done, done_id, cout;
   logic [W-1:0] sum;

   int n_chk  = 0;
   int n_fail = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
      .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
      .ack0(ack0), .ack1(ack1), .busy(busy), .done(done), .done_id(done_id),
      .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           cin;
      logic [W-1:0] exp_sum;
      bit           exp_cout;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain WIDTH+1-bit addition.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit c);
      return (W + 1)'(a) + (W + 1)'(b) + (W + 1)'(c);
   endfunction

   task automatic run_op(input string name, input bit id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit c, input bit scramble,
                         input logic [W-1:0] exp_sum, input bit exp_cout);
      int  n;
      bit  got;
      if (id) begin a1 = a; b1 = b; cin1 = c; req1 = 1'b1; end
      else    begin a0 = a; b0 = b; cin0 = c; req0 = 1'b1; end
      got = 1'b0;
      for (n = 0; n < 40 && !got; n++) begin
         tick();
         if (id ? ack1 : ack0) got = 1'b1;
      end
      check({name, " ack"}, 32'(got), 32'd1);
      if (id) req1 = 1'b0; else req0 = 1'b0;
      got = 1'b0;
      n = 0;
      while (!got && n < 40) begin
         if (scramble) begin
            a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
         end
         tick();
         n++;
         if (done) got = 1'b1;
      end
      check({name, " done seen"}, 32'(got), 32'd1);
      check({name, " latency"}, 32'(n), 32'(W));
      check({name, " sum"}, 32'(sum), 32'(exp_sum));
      check({name, " cout"}, 32'(cout), 32'(exp_cout));
      check({name, " done_id"}, 32'(done_id), 32'(id));
      tick();
      check({name, " busy after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vec_t         vecs[7];
      int           n;
      bit           got;
      int           ndone;
      bit           rid, rc;
      logic [W-1:0] ra, rb;
      logic [W:0]   rexp;

      vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[1] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[3] = '{1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
      vecs[4] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[5] = '{1'b1, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
      vecs[6] = '{1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

      // Reset state
      tick(); tick();
      check("reset ack0", 32'(ack0), 0);
      check("reset ack1", 32'(ack1), 0);
      check("reset busy", 32'(busy), 0);
      check("reset done", 32'(done), 0);
      check("reset done_id", 32'(done_id), 0);
      check("reset sum", 32'(sum), 0);
      check("reset cout", 32'(cout), 0);
      reset = 1'b0;
      tick();

      // Cycle-exact first operation: 0x5A + 0x33
      a0 = 8'h5A; b0 = 8'h33; cin0 = 1'b0; req0 = 1'b1;
      tick();
      check("first ack0", 32'(ack0), 1);
      check("first busy", 32'(busy), 1);
      req0 = 1'b0;
      for (int j = 1; j <= W + 1; j++) begin
         tick();
         check($sformatf("first ack0 e%0d", j), 32'(ack0), 0);
         check($sformatf("first done e%0d", j), 32'(done), 32'(j == W));
         check($sformatf("first busy e%0d", j), 32'(busy), 32'(j <= W));
         if (j == W) begin
            check("first sum", 32'(sum), 32'h8D);
            check("first cout", 32'(cout), 0);
            check("first done_id", 32'(done_id), 0);
         end
      end

      // Directed table
      for (int i = 0; i < 7; i++)
         run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                vecs[i].exp_sum, vecs[i].exp_cout);

      // Contention from reset: both held, results alternate 0,1,0,1
      reset = 1'b1; tick(); reset = 1'b0;
      a0 = 8'h10; b0 = 8'h20; cin0 = 1'b0;
      a1 = 8'h7F; b1 = 8'h01; cin1 = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0; n = 0;
         while (!got && n < 30) begin tick(); n++; if (done) got = 1'b1; end
         check($sformatf("rr%0d done seen", k), 32'(got), 1);
         check($sformatf("rr%0d done_id", k), 32'(done_id), 32'(k % 2));
         check($sformatf("rr%0d sum", k), 32'(sum), (k % 2) ? 32'h80 : 32'h30);
         if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      end
      tick(); tick();
      check("rr idle busy", 32'(busy), 0);

      // Request raised while busy is held and served at the next IDLE edge
      a0 = 8'h05; b0 = 8'h06; cin0 = 1'b0; req0 = 1'b1;
      got = 1'b0;
      for (n = 0; n < 20 && !got; n++) begin tick(); if (ack0) got = 1'b1; end
      check("pend ack0", 32'(got), 1);
      req0 = 1'b0;
      tick(); tick();
      a1 = 8'h01; b1 = 8'h02; cin1 = 1'b0; req1 = 1'b1;
      got = 1'b0; n = 0;
      while (!got && n < 20) begin tick(); n++; if (done) got = 1'b1; end
      check("pend first done", 32'(got), 1);
      check("pend first id", 32'(done_id), 0);
      check("pend first sum", 32'(sum), 32'h0B);
      tick();
      check("pend no ack in done->idle", 32'(ack1), 0);
      check("pend idle busy", 32'(busy), 0);
      tick();
      check("pend ack1", 32'(ack1), 1);
      req1 = 1'b0;
      got = 1'b0; n = 0;
      while (!got && n < 20) begin tick(); n++; if (done) got = 1'b1; end
      check("pend second done", 32'(got), 1);
      check("pend second latency", 32'(n), 32'(W));
      check("pend second id", 32'(done_id), 1);
      check("pend second sum", 32'(sum), 32'h03);
      check("pend second cout", 32'(cout), 0);
      tick();

      // Reset in the middle of SHIFT aborts the operation
      a0 = 8'hAA; b0 = 8'h55; cin0 = 1'b0; req0 = 1'b1;
      tick();
      check("abort ack0", 32'(ack0), 1);
      req0 = 1'b0;
      tick(); tick(); tick();
      #1 reset = 1'b1;
      #1;
      check("abort busy", 32'(busy), 0);
      check("abort done", 32'(done), 0);
      check("abort sum", 32'(sum), 0);
      check("abort cout", 32'(cout), 0);
      check("abort done_id", 32'(done_id), 0);
      reset = 1'b0;
      ndone = 0;
      for (int j = 0; j < 14; j++) begin tick(); if (done || busy) ndone++; end
      check("abort no resume", 32'(ndone), 0);
      run_op("after abort", 1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1);

      // Operands scrambled after capture have no effect
      run_op("stable", 1'b0, 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0);

      // Random operations against the arithmetic reference
      for (int i = 0; i < 16; i++) begin
         rid  = 1'($urandom);
         ra   = W'($urandom);
         rb   = W'($urandom);
         rc   = 1'($urandom);
         rexp = ref_add(ra, rb, rc);
         run_op($sformatf("rand%0d", i), rid, ra, rb, rc, 1'b0, rexp[W-1:0], rexp[W]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
